// File: rtl/cdma_block_seq_if.sv
// Request and CDMA-wrapper signals of the block sequencer.
// master: requester plus wrapper side; slave: the sequencer.
interface cdma_block_seq_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int TRANS_WIDTH = 16,
    parameter int DIM_WIDTH   = 10
);
    logic                   start;
    logic [ADDR_WIDTH-1:0]  src_base;
    logic [ADDR_WIDTH-1:0]  dst_base;
    logic [TRANS_WIDTH-1:0] row_len;
    logic [DIM_WIDTH-1:0]   row_num;
    logic [DIM_WIDTH-1:0]   plane_num;
    logic [ADDR_WIDTH-1:0]  src_row_stride;
    logic [ADDR_WIDTH-1:0]  src_plane_stride;
    logic [ADDR_WIDTH-1:0]  dst_row_stride;
    logic [ADDR_WIDTH-1:0]  dst_plane_stride;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [ADDR_WIDTH-1:0]  cdma_src_addr;
    logic [ADDR_WIDTH-1:0]  cdma_dst_addr;
    logic [TRANS_WIDTH-1:0] cdma_trans_len;
    logic                   cdma_start;
    logic                   cdma_done;

    modport master (
        output start, src_base, dst_base, row_len,
        output row_num, plane_num,
        output src_row_stride, src_plane_stride,
        output dst_row_stride, dst_plane_stride,
        output cdma_done,
        input  busy, done, err,
        input  cdma_src_addr, cdma_dst_addr,
        input  cdma_trans_len, cdma_start
    );

    modport slave (
        input  start, src_base, dst_base, row_len,
        input  row_num, plane_num,
        input  src_row_stride, src_plane_stride,
        input  dst_row_stride, dst_plane_stride,
        input  cdma_done,
        output busy, done, err,
        output cdma_src_addr, cdma_dst_addr,
        output cdma_trans_len, cdma_start
    );
endinterface

// File: rtl/cdma_block_seq.sv
// Walks a planes x rows block, issuing one CDMA transfer per row.
// Define CDMA_SEQ_TIMEOUT_EN to build the WAIT-state watchdog.
module cdma_block_seq #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TRANS_WIDTH    = 16,
    parameter int DIM_WIDTH      = 10,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic             clk,
    input logic             rst,
    cdma_block_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        NEXT
    } state_e;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e                 state_q;
    logic [ADDR_WIDTH-1:0]  src_row_q;
    logic [ADDR_WIDTH-1:0]  dst_row_q;
    logic [ADDR_WIDTH-1:0]  src_pl_q;
    logic [ADDR_WIDTH-1:0]  dst_pl_q;
    logic [ADDR_WIDTH-1:0]  src_rs_q;
    logic [ADDR_WIDTH-1:0]  src_ps_q;
    logic [ADDR_WIDTH-1:0]  dst_rs_q;
    logic [ADDR_WIDTH-1:0]  dst_ps_q;
    logic [TRANS_WIDTH-1:0] len_q;
    logic [DIM_WIDTH-1:0]   row_num_q;
    logic [DIM_WIDTH-1:0]   plane_num_q;
    logic [DIM_WIDTH-1:0]   row_cnt_q;
    logic [DIM_WIDTH-1:0]   plane_cnt_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   cstart_q;

    logic [ADDR_WIDTH-1:0]  src_row_d;
    logic [ADDR_WIDTH-1:0]  dst_row_d;
    logic [ADDR_WIDTH-1:0]  src_pl_d;
    logic [ADDR_WIDTH-1:0]  dst_pl_d;
    logic                   row_last;
    logic                   plane_last;
    logic                   zero_req;

    // Separate row and plane bases keep the walk adder-only.
    assign src_row_d = src_row_q + src_rs_q;
    assign dst_row_d = dst_row_q + dst_rs_q;
    assign src_pl_d  = src_pl_q + src_ps_q;
    assign dst_pl_d  = dst_pl_q + dst_ps_q;

    assign row_last   = (row_cnt_q == row_num_q - DIM_WIDTH'(1));
    assign plane_last = (plane_cnt_q == plane_num_q - DIM_WIDTH'(1));
    assign zero_req   = (bus.row_num == '0) ||
                        (bus.plane_num == '0) ||
                        (bus.row_len == '0);

`ifdef CDMA_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_q;
    logic            err_q;
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            src_row_q   <= '0;
            dst_row_q   <= '0;
            src_pl_q    <= '0;
            dst_pl_q    <= '0;
            src_rs_q    <= '0;
            src_ps_q    <= '0;
            dst_rs_q    <= '0;
            dst_ps_q    <= '0;
            len_q       <= '0;
            row_num_q   <= '0;
            plane_num_q <= '0;
            row_cnt_q   <= '0;
            plane_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cstart_q    <= 1'b0;
`ifdef CDMA_SEQ_TIMEOUT_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            done_q   <= 1'b0;
            cstart_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        len_q       <= bus.row_len;
                        row_num_q   <= bus.row_num;
                        plane_num_q <= bus.plane_num;
                        src_rs_q    <= bus.src_row_stride;
                        src_ps_q    <= bus.src_plane_stride;
                        dst_rs_q    <= bus.dst_row_stride;
                        dst_ps_q    <= bus.dst_plane_stride;
`ifdef CDMA_SEQ_TIMEOUT_EN
                        err_q       <= 1'b0;
`endif
                        if (zero_req) begin
                            done_q <= 1'b1;
                        end else begin
                            src_row_q   <= bus.src_base;
                            dst_row_q   <= bus.dst_base;
                            src_pl_q    <= bus.src_base;
                            dst_pl_q    <= bus.dst_base;
                            row_cnt_q   <= '0;
                            plane_cnt_q <= '0;
                            busy_q      <= 1'b1;
                            cstart_q    <= 1'b1;
                            state_q     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
`ifdef CDMA_SEQ_TIMEOUT_EN
                    wd_q    <= '0;
`endif
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.cdma_done) begin
                        state_q <= NEXT;
`ifdef CDMA_SEQ_TIMEOUT_EN
                    end else if (wd_q == WD_LAST) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
`endif
                    end
                end
                NEXT: begin
                    if (!row_last) begin
                        row_cnt_q <= row_cnt_q + DIM_WIDTH'(1);
                        src_row_q <= src_row_d;
                        dst_row_q <= dst_row_d;
                        cstart_q  <= 1'b1;
                        state_q   <= ISSUE;
                    end else if (!plane_last) begin
                        row_cnt_q   <= '0;
                        plane_cnt_q <= plane_cnt_q + DIM_WIDTH'(1);
                        src_pl_q    <= src_pl_d;
                        dst_pl_q    <= dst_pl_d;
                        src_row_q   <= src_pl_d;
                        dst_row_q   <= dst_pl_d;
                        cstart_q    <= 1'b1;
                        state_q     <= ISSUE;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.cdma_start     = cstart_q;
    assign bus.cdma_src_addr  = src_row_q;
    assign bus.cdma_dst_addr  = dst_row_q;
    assign bus.cdma_trans_len = len_q;

endmodule

// File: tb/tb_cdma_block_seq.sv
// Scoreboard bench for cdma_block_seq with a 4-cycle wrapper model.
// Expected transfers/done events are queued by stimulus, popped by a monitor.
`timescale 1ns/1ps
module tb_cdma_block_seq;
    localparam int AW = 32;
    localparam int TW = 16;
    localparam int DW = 10;
    localparam int TO = 8;

    typedef struct {
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [TW-1:0] len;
        int            gap;
    } xfer_t;

    // mode 0: absolute cycle, 1: after last cdma_done, 2: after last cdma_start
    typedef struct {
        logic err;
        int   mode;
        int   dly;
    } done_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cdma_block_seq_if #(.ADDR_WIDTH(AW), .TRANS_WIDTH(TW), .DIM_WIDTH(DW)) bus();

    cdma_block_seq #(
        .ADDR_WIDTH(AW), .TRANS_WIDTH(TW),
        .DIM_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    xfer_t xq[$];
    done_t dq[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_starts = 0;
    int n_dones = 0;
    int last_start_cyc = -100;
    int last_cdone_cyc = -100;
    int pend = 0;
    bit wrap_en = 1'b1;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Wrapper model: cdma_done four cycles after each cdma_start.
    initial begin
        bus.cdma_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.cdma_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.cdma_done = 1'b1;
                    last_cdone_cyc = cyc;
                end
            end
            if (bus.cdma_start && wrap_en) pend = 4;
        end
    end

    // Monitor
    initial forever begin
        xfer_t e;
        done_t d;
        int refc;
        @(negedge clk);
        if (bus.cdma_start) begin
            n_starts++;
            checks++;
            if (xq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_cdma_start src=%h dst=%h",
                         bus.cdma_src_addr, bus.cdma_dst_addr);
            end else begin
                e = xq.pop_front();
                if (bus.cdma_src_addr !== e.src ||
                    bus.cdma_dst_addr !== e.dst ||
                    bus.cdma_trans_len !== e.len) begin
                    errors++;
                    $display("FAIL xfer got src=%h dst=%h len=%0d exp src=%h dst=%h len=%0d",
                             bus.cdma_src_addr, bus.cdma_dst_addr, bus.cdma_trans_len,
                             e.src, e.dst, e.len);
                end
                if (e.gap != 0) begin
                    checks++;
                    if (cyc - last_start_cyc != e.gap) begin
                        errors++;
                        $display("FAIL start_gap got=%0d exp=%0d",
                                 cyc - last_start_cyc, e.gap);
                    end
                end
            end
            last_start_cyc = cyc;
        end
        if (bus.done) begin
            n_dones++;
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done err=%b busy=%b", bus.err, bus.busy);
            end else begin
                d = dq.pop_front();
                refc = (d.mode == 1) ? last_cdone_cyc :
                       (d.mode == 2) ? last_start_cyc : 0;
                if (bus.err !== d.err || bus.busy !== 1'b0 ||
                    cyc - refc != d.dly) begin
                    errors++;
                    $display("FAIL done got err=%b busy=%b dly=%0d exp err=%b busy=0 dly=%0d",
                             bus.err, bus.busy, cyc - refc, d.err, d.dly);
                end
            end
        end
    end

    task automatic push_x(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [TW-1:0] l, input int g);
        xfer_t e;
        e.src = s; e.dst = d; e.len = l; e.gap = g;
        xq.push_back(e);
    endtask

    task automatic push_d(input logic er, input int m, input int dl);
        done_t d;
        d.err = er; d.mode = m; d.dly = dl;
        dq.push_back(d);
    endtask

    task automatic go(input logic [AW-1:0] sb, input logic [AW-1:0] db,
                      input logic [AW-1:0] srs, input logic [AW-1:0] sps,
                      input logic [AW-1:0] drs, input logic [AW-1:0] dps,
                      input logic [TW-1:0] len,
                      input logic [DW-1:0] rn, input logic [DW-1:0] pn);
        bus.src_base = sb;
        bus.dst_base = db;
        bus.src_row_stride = srs;
        bus.src_plane_stride = sps;
        bus.dst_row_stride = drs;
        bus.dst_plane_stride = dps;
        bus.row_len = len;
        bus.row_num = rn;
        bus.plane_num = pn;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_dones(input int tgt, input int budget, input string nm);
        int n;
        n = 0;
        while (n_dones < tgt && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n_dones < tgt) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout dones=%0d exp=%0d", nm, n_dones, tgt);
        end
    endtask

    task automatic wait_starts(input int tgt, input int budget, input string nm);
        int n;
        n = 0;
        while (n_starts < tgt && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n_starts < tgt) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout starts=%0d exp=%0d", nm, n_starts, tgt);
        end
    endtask

    task automatic chk_bit(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", nm, got, exp);
        end
    endtask

    task automatic chk_idle_zero(input string nm);
        logic [2*AW+TW+4:0] v;
        v = {bus.busy, bus.done, bus.err, bus.cdma_start, bus.cdma_src_addr,
             bus.cdma_dst_addr, bus.cdma_trans_len, 1'b0};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL %s outputs got=%h exp=0", nm, v);
        end
    endtask

    initial begin
        int s0;
        int d0;
        logic [DW-1:0] rn;
        logic [DW-1:0] pn;
        logic [TW-1:0] ln;
        bus.start = 1'b0;
        bus.src_base = '0;
        bus.dst_base = '0;
        bus.row_len = '0;
        bus.row_num = '0;
        bus.plane_num = '0;
        bus.src_row_stride = '0;
        bus.src_plane_stride = '0;
        bus.dst_row_stride = '0;
        bus.dst_plane_stride = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic 3D walk
        push_x(32'h1000, 32'h8000, 16, 0);
        push_x(32'h1040, 32'h8040, 16, 6);
        push_x(32'h1080, 32'h8080, 16, 6);
        push_x(32'h1400, 32'h8200, 16, 6);
        push_x(32'h1440, 32'h8240, 16, 6);
        push_x(32'h1480, 32'h8280, 16, 6);
        push_d(1'b0, 1, 2);
        go(32'h1000, 32'h8000, 32'h40, 32'h400, 32'h40, 32'h200, 16, 3, 2);
        chk_bit("busy_after_accept", bus.busy, 1'b1);
        wait_dones(1, 100, "basic");
        chk_bit("err_after_basic", bus.err, 1'b0);

        // Zero-size requests: row_num, plane_num, row_len each zero
        for (int i = 0; i < 3; i++) begin
            rn = (i == 0) ? 10'd0 : 10'd2;
            pn = (i == 1) ? 10'd0 : 10'd2;
            ln = (i == 2) ? 16'd0 : 16'd4;
            @(negedge clk);
            push_d(1'b0, 0, cyc + 1);
            go(32'hA000, 32'hB000, 32'h4, 32'h8, 32'h4, 32'h8, ln, rn, pn);
            for (int j = 0; j < 3; j++) begin
                chk_bit("zero_busy", bus.busy, 1'b0);
                @(negedge clk);
            end
            wait_dones(2 + i, 10, "zero");
        end

        // Start while busy is ignored
        @(negedge clk);
        s0 = n_starts;
        push_x(32'h2000, 32'h3000, 8, 0);
        push_x(32'h2010, 32'h3020, 8, 6);
        push_d(1'b0, 1, 2);
        go(32'h2000, 32'h3000, 32'h10, 32'h0, 32'h20, 32'h0, 8, 2, 1);
        wait_starts(s0 + 1, 10, "busy_start");
        repeat (2) @(negedge clk);
        go(32'h9000, 32'h7000, 32'h4, 32'h4, 32'h4, 32'h4, 3, 5, 5);
        wait_dones(5, 50, "busy_start");

        // Source address wrap
        @(negedge clk);
        push_x(32'hFFFF_FFC0, 32'h0100, 1, 0);
        push_x(32'h0000_0000, 32'h0104, 1, 6);
        push_d(1'b0, 1, 2);
        go(32'hFFFF_FFC0, 32'h0100, 32'h40, 32'h0, 32'h4, 32'h0, 1, 2, 1);
        wait_dones(6, 50, "wrap");

        // Reset in WAIT of transfer 2
        @(negedge clk);
        s0 = n_starts;
        push_x(32'h5000, 32'h6000, 4, 0);
        push_x(32'h5100, 32'h6100, 4, 6);
        go(32'h5000, 32'h6000, 32'h100, 32'h0, 32'h100, 32'h0, 4, 3, 1);
        wait_starts(s0 + 2, 40, "midrst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_zero("mid_reset");
        rst = 1'b0;
        d0 = n_dones;
        repeat (12) @(negedge clk);
        checks++;
        if (n_starts != s0 + 2 || n_dones != d0) begin
            errors++;
            $display("FAIL post_reset_activity starts=%0d dones=%0d exp starts=%0d dones=%0d",
                     n_starts, n_dones, s0 + 2, d0);
        end

`ifdef CDMA_SEQ_TIMEOUT_EN
        // Watchdog: cdma_done withheld
        @(negedge clk);
        wrap_en = 1'b0;
        push_x(32'h0100, 32'h0200, 2, 0);
        push_d(1'b1, 2, TO + 1);
        go(32'h0100, 32'h0200, 32'h10, 32'h0, 32'h10, 32'h0, 2, 2, 1);
        wait_dones(d0 + 1, 40, "timeout");
        repeat (3) @(negedge clk);
        chk_bit("err_sticky", bus.err, 1'b1);
        wrap_en = 1'b1;
        push_x(32'h0300, 32'h0400, 2, 0);
        push_d(1'b0, 1, 2);
        go(32'h0300, 32'h0400, 32'h0, 32'h0, 32'h0, 32'h0, 2, 1, 1);
        chk_bit("err_cleared", bus.err, 1'b0);
        wait_dones(d0 + 2, 40, "after_timeout");
`endif

        repeat (3) @(negedge clk);
        checks++;
        if (xq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL leftover_expect xfers=%0d dones=%0d exp=0",
                     xq.size(), dq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end
endmodule
